rs_bank: RTL and testbench
==========================

# rs_bank

Parametrised reservation station for the Tomasulo core: holds up to DEPTH waiting instructions for one functional unit, captures operands from the common data bus (CDB), and dispatches the oldest ready entry through a valid/ready handshake. It sits between the issue stage, which allocates an entry and receives that entry's rename tag, and the functional unit, whose result returns on the CDB under the same tag.

## Interface
- DEPTH, 4, number of entries (2..8)
- DATA_W, 32, operand width
- TAG_W, 4, rename tag width; tag 0 means "value present"
- OP_W, 5, opcode width
- RS_BASE, 1, tag of entry 0; entry i owns tag RS_BASE+i; RS_BASE≥1, RS_BASE+DEPTH-1 ≤ 2^TAG_W-1
- clk  in  1  clock, all state on rising edge
- nRST  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of all entries (misprediction/exception)
- in_valid  in  1  issue stage presents an instruction
- in_ready  out  1  a free entry exists
- in_op  in  OP_W  opcode
- in_v1, in_v2  in  DATA_W  operand values (meaningful when matching q is 0)
- in_q1, in_q2  in  TAG_W  producer tags (0 = value valid)
- in_tag  out  TAG_W  tag that will be assigned to the accepted instruction
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- out_valid  out  1  a ready entry is offered
- out_ready  in  1  functional unit accepts
- out_op  out  OP_W, out_v1/out_v2  out  DATA_W, out_tag  out  TAG_W  dispatched entry contents and tag
- count  out  clog2(DEPTH+1)  number of busy entries

## Operation
- Entry state: busy, op, qj, vj, qk, vk, rank (age, 0 = oldest among busy).
- Reset (nRST=0) or flush=1: all busy cleared, ranks cleared; takes priority over every other event in that cycle.
- Allocation: accept when in_valid && in_ready; writes lowest-index free entry; in_tag = RS_BASE + that index (RS_BASE when empty, don't-care when full).
- in_ready = (count < DEPTH), from registered state only; a slot freed by dispatch this cycle is not reusable until next cycle.
- New entry rank = number of busy entries remaining after this cycle's dispatch.
- CDB capture: if cdb_valid && cdb_tag≠0, every busy entry with qj==cdb_tag loads vj=cdb_data, qj=0; likewise qk/vk. cdb_tag=0 ignored.
- Bypass: an instruction allocated in the same cycle with in_q1 (in_q2)==cdb_tag≠0 stores cdb_data and tag 0 instead of in_v1/in_q1.
- Ready: busy && qj==0 && qk==0, evaluated on registered state.
- Select: ready entry with smallest rank; out_valid = any ready.
- Dispatch: on out_valid && out_ready the selected entry is freed at the edge; all entries with larger rank decrement rank by 1.
- When out_valid=0, out_op/out_v1/out_v2/out_tag drive 0.
- Selection is recomputed every cycle; a ready entry never becomes unready, so out_valid never drops without dispatch, reset or flush.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_* =0, in_tag=RS_BASE.
- Allocation of an already-ready instruction → out_valid earliest next cycle (1-cycle latency).
- CDB wakeup in cycle N → entry eligible for dispatch in N+1.
- Dispatch output is combinational from registers; consumer samples at the accepting edge.
- Allocation, CDB capture and dispatch may all occur in one cycle; count updates by +1, −1, or 0 accordingly.
- flush with in_valid high: instruction discarded, not allocated.

## Test plan
- Reset then allocate op=3, v1=10,q1=0, v2=20,q2=0 → in_tag=1; next cycle out_valid=1, out_op=3, out_v1=10, out_v2=20, out_tag=1; accept → count 0.
- Fill DEPTH=4 with q1=7 each → in_ready=0, count=4, out_valid=0; 5th in_valid ignored; cdb tag 7 data 0x55 → next cycle out_valid=1, out_tag=1, out_v1=0x55.
- Allocate A(q1=9) then B(ready); B dispatched first; cdb tag 9 → A dispatched after; ages ordered oldest-first when both ready.
- Same-cycle bypass: in_q2=5, cdb_valid tag 5 data 0xAB → entry stores v2=0xAB, ready next cycle.
- Full bank with out_ready=1 and in_valid=1 same cycle → dispatch occurs, no allocation; next cycle in_ready=1, allocation lands in the freed index.
- flush mid-operation with 3 busy entries → next cycle count=0, out_valid=0, in_ready=1, in_tag=1.

Source files
------------

// File: rtl/rs_bank.sv
// rs_bank: reservation station for one functional unit of the Tomasulo core.
// Holds up to DEPTH waiting instructions, captures operands from the CDB and
// dispatches the oldest ready entry through a valid/ready handshake.
// Ports:
//   clk, nRST (sync, active-low), flush     - clock, reset, pipeline clear
//   in_valid/in_ready, in_op, in_v1/in_v2,  - issue-side allocation; in_tag is
//   in_q1/in_q2, in_tag                        the tag given to the accepted entry
//   cdb_valid, cdb_tag, cdb_data            - common data bus broadcast
//   out_valid/out_ready, out_op, out_v1,    - dispatch to the functional unit
//   out_v2, out_tag
//   count                                   - number of busy entries
module rs_bank #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned OP_W    = 5,
   parameter int unsigned RS_BASE = 1
) (
   input  logic                         clk,
   input  logic                         nRST,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [OP_W-1:0]              in_op,
   input  logic [DATA_W-1:0]            in_v1,
   input  logic [DATA_W-1:0]            in_v2,
   input  logic [TAG_W-1:0]             in_q1,
   input  logic [TAG_W-1:0]             in_q2,
   output logic [TAG_W-1:0]             in_tag,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [DATA_W-1:0]            cdb_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OP_W-1:0]              out_op,
   output logic [DATA_W-1:0]            out_v1,
   output logic [DATA_W-1:0]            out_v2,
   output logic [TAG_W-1:0]             out_tag,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned RANK_W = IDX_W;

   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [OP_W-1:0]   op_q [DEPTH];
   logic [OP_W-1:0]   op_d [DEPTH];
   logic [TAG_W-1:0]  qj_q [DEPTH];
   logic [TAG_W-1:0]  qj_d [DEPTH];
   logic [TAG_W-1:0]  qk_q [DEPTH];
   logic [TAG_W-1:0]  qk_d [DEPTH];
   logic [DATA_W-1:0] vj_q [DEPTH];
   logic [DATA_W-1:0] vj_d [DEPTH];
   logic [DATA_W-1:0] vk_q [DEPTH];
   logic [DATA_W-1:0] vk_d [DEPTH];
   logic [RANK_W-1:0] rank_q [DEPTH];
   logic [RANK_W-1:0] rank_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   logic [DEPTH-1:0]  ready_c;
   logic              free_found_c;
   logic [IDX_W-1:0]  free_idx_c;
   logic              sel_found_c;
   logic [IDX_W-1:0]  sel_idx_c;
   logic [RANK_W-1:0] sel_rank_c;
   logic              alloc_c, disp_c, cdb_hit_c;
   logic [RANK_W-1:0] new_rank_c;

   // Lowest free slot and oldest ready entry, both from registered state only.
   always_comb begin
      ready_c      = '0;
      free_found_c = 1'b0;
      free_idx_c   = '0;
      sel_found_c  = 1'b0;
      sel_idx_c    = '0;
      sel_rank_c   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_c[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
         if (!busy_q[i] && !free_found_c) begin
            free_found_c = 1'b1;
            free_idx_c   = IDX_W'(i);
         end
         if (ready_c[i] && (!sel_found_c || (rank_q[i] < sel_rank_c))) begin
            sel_found_c = 1'b1;
            sel_idx_c   = IDX_W'(i);
            sel_rank_c  = rank_q[i];
         end
      end
   end

   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign in_tag    = TAG_W'(RS_BASE) + TAG_W'(free_idx_c);
   assign out_valid = sel_found_c;
   assign out_op    = out_valid ? op_q[sel_idx_c] : '0;
   assign out_v1    = out_valid ? vj_q[sel_idx_c] : '0;
   assign out_v2    = out_valid ? vk_q[sel_idx_c] : '0;
   assign out_tag   = out_valid ? (TAG_W'(RS_BASE) + TAG_W'(sel_idx_c)) : '0;
   assign count     = count_q;

   assign alloc_c    = in_valid && in_ready;
   assign disp_c     = out_valid && out_ready;
   assign cdb_hit_c  = cdb_valid && (cdb_tag != '0);
   // New entry is youngest among the entries that survive this cycle.
   assign new_rank_c = RANK_W'(count_q - CNT_W'(disp_c));

   // Per-entry next state: CDB capture, dispatch/age compaction, allocation.
   always_comb begin
      busy_d  = busy_q;
      count_d = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         op_d[i]   = op_q[i];
         qj_d[i]   = qj_q[i];
         qk_d[i]   = qk_q[i];
         vj_d[i]   = vj_q[i];
         vk_d[i]   = vk_q[i];
         rank_d[i] = rank_q[i];

         if (cdb_hit_c && busy_q[i] && (qj_q[i] == cdb_tag)) begin
            vj_d[i] = cdb_data;
            qj_d[i] = '0;
         end
         if (cdb_hit_c && busy_q[i] && (qk_q[i] == cdb_tag)) begin
            vk_d[i] = cdb_data;
            qk_d[i] = '0;
         end
         if (disp_c && busy_q[i] && (rank_q[i] > sel_rank_c)) begin
            rank_d[i] = rank_q[i] - RANK_W'(1);
         end
         if (disp_c && (IDX_W'(i) == sel_idx_c)) begin
            busy_d[i] = 1'b0;
         end
         // Free slot comes from registered state, so it never collides with dispatch.
         if (alloc_c && (IDX_W'(i) == free_idx_c)) begin
            busy_d[i] = 1'b1;
            op_d[i]   = in_op;
            rank_d[i] = new_rank_c;
            if (cdb_hit_c && (in_q1 == cdb_tag)) begin
               vj_d[i] = cdb_data;
               qj_d[i] = '0;
            end else begin
               vj_d[i] = in_v1;
               qj_d[i] = in_q1;
            end
            if (cdb_hit_c && (in_q2 == cdb_tag)) begin
               vk_d[i] = cdb_data;
               qk_d[i] = '0;
            end else begin
               vk_d[i] = in_v2;
               qk_d[i] = in_q2;
            end
         end
      end
      case ({alloc_c, disp_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset and flush clear everything and win over all events.
   always_ff @(posedge clk) begin
      if (!nRST || flush) begin
         busy_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= '0;
            qj_q[i]   <= '0;
            qk_q[i]   <= '0;
            vj_q[i]   <= '0;
            vk_q[i]   <= '0;
            rank_q[i] <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= op_d[i];
            qj_q[i]   <= qj_d[i];
            qk_q[i]   <= qk_d[i];
            vj_q[i]   <= vj_d[i];
            vk_q[i]   <= vk_d[i];
            rank_q[i] <= rank_d[i];
         end
      end
   end

   logic unused_c;
   assign unused_c = free_found_c;

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed bench for rs_bank; expected dispatches go into a
// scoreboard queue and a monitor checks every accepted dispatch in order.
module tb_rs_bank;

   logic        clk = 1'b0;
   logic        nRST, flush, in_valid, in_ready;
   logic [4:0]  in_op;
   logic [31:0] in_v1, in_v2;
   logic [3:0]  in_q1, in_q2, in_tag;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        out_valid, out_ready;
   logic [4:0]  out_op;
   logic [31:0] out_v1, out_v2;
   logic [3:0]  out_tag;
   logic [2:0]  count;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rs_bank #(.DEPTH(4), .DATA_W(32), .TAG_W(4), .OP_W(5), .RS_BASE(1)) dut (
      .clk(clk), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2), .in_tag(in_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_v1(out_v1), .out_v2(out_v2), .out_tag(out_tag), .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input logic [4:0] op, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [3:0] tag);
      exp_t e;
      e.op = op; e.v1 = v1; e.v2 = v2; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [3:0] q1,
                        input logic [31:0] v2, input logic [3:0] q2);
      in_valid = 1'b1; in_op = op; in_v1 = v1; in_q1 = q1; in_v2 = v2; in_q2 = q2;
   endtask

   // Monitor: every accepted dispatch must match the head of the scoreboard.
   always @(negedge clk) begin
      if (nRST && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_dispatch: got tag %0d op %0d expected none", out_tag, out_op);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("disp_op",  32'(out_op),  32'(e.op));
            chk("disp_v1",  out_v1,       e.v1);
            chk("disp_v2",  out_v2,       e.v2);
            chk("disp_tag", 32'(out_tag), 32'(e.tag));
         end
      end
   end

   initial begin
      nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_v1 = '0; in_v2 = '0;
      in_q1 = '0; in_q2 = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 nRST = 1'b1;
      mid();
      chk("rst_in_ready",  32'(in_ready),  1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_count",     32'(count),     0);
      chk("rst_out_op",    32'(out_op),    0);
      chk("rst_out_v1",    out_v1,         0);
      chk("rst_out_tag",   32'(out_tag),   0);
      chk("rst_in_tag",    32'(in_tag),    1);

      // Single ready instruction, one-cycle latency to out_valid.
      step(); issue(5'd3, 32'd10, 4'd0, 32'd20, 4'd0);
      mid();  chk("t1_in_tag", 32'(in_tag), 1);
      chk("t1_out_valid_same_cycle", 32'(out_valid), 0);
      push(5'd3, 32'd10, 32'd20, 4'd1);
      step(); in_valid = 1'b0; out_ready = 1'b1;
      mid();  chk("t1_out_valid", 32'(out_valid), 1);
      step(); out_ready = 1'b0;
      mid();  chk("t1_count_after", 32'(count), 0);

      // Fill with entries waiting on tag 7; 5th request ignored.
      for (int i = 0; i < 4; i++) begin
         step(); issue(5'(i + 1), 32'hDEAD, 4'd7, 32'(i), 4'd0);
         mid();  chk("t2_fill_tag", 32'(in_tag), 32'(i + 1));
      end
      step(); issue(5'd9, 32'd1, 4'd0, 32'd1, 4'd0);
      mid();
      chk("t2_in_ready_full", 32'(in_ready),  0);
      chk("t2_count_full",    32'(count),     4);
      chk("t2_out_valid",     32'(out_valid), 0);
      step(); in_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'h55;
      mid();  chk("t2_count_5th_ignored", 32'(count), 4);
      for (int i = 0; i < 4; i++) push(5'(i + 1), 32'h55, 32'(i), 4'(i + 1));
      step(); cdb_valid = 1'b0; out_ready = 1'b1;
      mid();  chk("t2_wake_tag", 32'(out_tag), 1);
      repeat (3) step();
      step(); out_ready = 1'b0;
      mid();  chk("t2_count_drained", 32'(count), 0);

      // Younger ready entry overtakes a waiting one.
      step(); issue(5'd10, 32'd0, 4'd9, 32'd1, 4'd0);
      step(); issue(5'd11, 32'd2, 4'd0, 32'd3, 4'd0);
      mid();  chk("t3_b_tag", 32'(in_tag), 2);
      push(5'd11, 32'd2, 32'd3, 4'd2);
      step(); in_valid = 1'b0; out_ready = 1'b1;
      step(); out_ready = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h99;
      mid();  chk("t3_a_not_ready", 32'(out_valid), 0);
      push(5'd10, 32'h99, 32'd1, 4'd1);
      step(); cdb_valid = 1'b0; out_ready = 1'b1;
      step(); out_ready = 1'b0;

      // Age order: Q (index 1) is older than R (index 0), Q dispatches first.
      step(); issue(5'd20, 32'd1, 4'd0, 32'd2, 4'd0);
      push(5'd20, 32'd1, 32'd2, 4'd1);
      step(); issue(5'd21, 32'd0, 4'd12, 32'd4, 4'd0);
      step(); in_valid = 1'b0; out_ready = 1'b1;
      step(); out_ready = 1'b0; issue(5'd22, 32'd5, 4'd0, 32'd6, 4'd0);
      mid();  chk("t3_r_tag", 32'(in_tag), 1);
      step(); in_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_data = 32'h77;
      push(5'd21, 32'h77, 32'd4, 4'd2);
      push(5'd22, 32'd5, 32'd6, 4'd1);
      step(); cdb_valid = 1'b0; out_ready = 1'b1;
      step();
      step(); out_ready = 1'b0;
      mid();  chk("t3_count_end", 32'(count), 0);

      // Same-cycle CDB bypass into a newly allocated entry.
      step(); issue(5'd30, 32'd3, 4'd0, 32'hFFFF, 4'd5);
      cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'hAB;
      push(5'd30, 32'd3, 32'hAB, 4'd1);
      step(); in_valid = 1'b0; cdb_valid = 1'b0;
      mid();  chk("t4_bypass_ready", 32'(out_valid), 1);
      step(); out_ready = 1'b1;
      step(); out_ready = 1'b0;

      // Full bank: dispatch and blocked allocation in one cycle, reuse next cycle.
      for (int i = 0; i < 4; i++) begin
         step(); issue(5'(40 + i), 32'(100 + i), 4'd0, 32'(200 + i), 4'd0);
         push(5'(40 + i), 32'(100 + i), 32'(200 + i), 4'(i + 1));
      end
      step(); issue(5'd50, 32'd7, 4'd0, 32'd8, 4'd0); out_ready = 1'b1;
      mid();  chk("t5_in_ready_full", 32'(in_ready), 0);
      step(); out_ready = 1'b0;
      mid();
      chk("t5_in_ready_freed", 32'(in_ready), 1);
      chk("t5_in_tag_freed",   32'(in_tag),   1);
      chk("t5_count_no_alloc", 32'(count),    3);
      push(5'd50, 32'd7, 32'd8, 4'd1);
      step(); in_valid = 1'b0;
      mid();  chk("t5_count_refill", 32'(count), 4);
      step(); out_ready = 1'b1;
      repeat (3) step();
      step(); out_ready = 1'b0;
      mid();  chk("t5_count_end", 32'(count), 0);

      // Flush with three waiting entries and a pending request.
      for (int i = 0; i < 3; i++) begin
         step(); issue(5'(60 + i), 32'd0, 4'd13, 32'd0, 4'd0);
      end
      step(); in_valid = 1'b0;
      mid();  chk("t6_count_pre", 32'(count), 3);
      step(); flush = 1'b1; issue(5'd63, 32'd1, 4'd0, 32'd1, 4'd0);
      step(); flush = 1'b0; in_valid = 1'b0;
      mid();
      chk("t6_count",     32'(count),     0);
      chk("t6_out_valid", 32'(out_valid), 0);
      chk("t6_in_ready",  32'(in_ready),  1);
      chk("t6_in_tag",    32'(in_tag),    1);
      step(); cdb_valid = 1'b1; cdb_tag = 4'd13; cdb_data = 32'h1; out_ready = 1'b1;
      step(); cdb_valid = 1'b0;
      mid();  chk("t6_no_ghost", 32'(out_valid), 0);
      step(); out_ready = 1'b0;

      step();
      chk("sb_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
